// File: rtl/uart_boot_loader.sv
// uart_boot_loader: pulls a length-prefixed, little-endian program image from
// the UART RX FIFO, writes it word by word into instruction memory, then
// releases the core via core_run. DONE and ERROR are terminal until reset.
module uart_boot_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_empty,
  input  logic [7:0]  uart_in,
  output logic        uart_rdreq,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_run,
  output logic [1:0]  status,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] n_q, n_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wl_q, wl_d;
  logic        fetching;
  logic [31:0] word;
  logic [31:0] idx_nxt;

  assign fetching = (state_q == S_LEN) || (state_q == S_DATA);
  // Read request must react to uart_empty in the same cycle, otherwise it could
  // fire on an empty FIFO; it is therefore a decode, gated off during reset.
  assign uart_rdreq = !rst && fetching && !pending_q && !uart_empty;
  assign word       = {uart_in, shreg_q[31:8]};
  assign idx_nxt    = idx_q + 32'd1;

  // Next-state logic: byte handshake, word assembly and load sequencing.
  always_comb begin
    state_d   = state_q;
    pending_d = uart_rdreq;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    n_d       = n_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wl_d      = wl_q;
    if (fetching && pending_q) begin
      shreg_d = word;
      bcnt_d  = bcnt_q + 2'd1;
      if (bcnt_q == 2'd3) begin
        if (state_q == S_LEN) begin
          n_d = word;
          if (word == 32'd0)                state_d = S_DONE;
          else if (word > 32'(MAX_WORDS))   state_d = S_ERR;
          else                              state_d = S_DATA;
        end else begin
          state_d = S_WRITE;
          wdata_d = word;
          addr_d  = ADDR_BASE + (idx_q << 2);
        end
      end
    end
    if (state_q == S_WRITE) begin
      idx_d   = idx_nxt;
      wl_d    = wl_q + 32'd1;
      state_d = (idx_nxt == n_q) ? S_DONE : S_DATA;
    end
  end

  // State registers; memory contents are never touched by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LEN;
      pending_q <= 1'b0;
      bcnt_q    <= 2'd0;
      shreg_q   <= 32'd0;
      n_q       <= 32'd0;
      idx_q     <= 32'd0;
      addr_q    <= ADDR_BASE;
      wdata_q   <= 32'd0;
      wl_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wl_q      <= wl_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    status = 2'd0;
    case (state_q)
      S_LEN:           status = 2'd0;
      S_DATA, S_WRITE: status = 2'd1;
      S_DONE:          status = 2'd2;
      S_ERR:           status = 2'd3;
      default:         status = 2'd0;
    endcase
  end

  assign imem_we      = (state_q == S_WRITE);
  assign core_run     = (state_q == S_DONE);
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: FIFO model feeding an image byte queue, a
// per-cycle checker against the expected write list, and directed timing checks.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_empty = 1'b1;
  logic [7:0]  uart_in = 8'h00;
  logic        uart_rdreq, imem_we, core_run;
  logic [31:0] imem_addr, imem_wdata, words_loaded;
  logic [1:0]  status;
  logic        w_rdreq, w_we, w_core_run;
  logic [31:0] w_addr, w_wdata, w_words_loaded;
  logic [1:0]  w_status;

  uart_boot_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(4)) u_dut (
    .clk(clk), .rst(rst), .uart_empty(uart_empty), .uart_in(uart_in),
    .uart_rdreq(uart_rdreq), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_run(core_run), .status(status),
    .words_loaded(words_loaded));

  // Same stimulus, high base address to exercise address wrap.
  uart_boot_loader #(.ADDR_BASE(32'hFFFF_FFFC), .MAX_WORDS(4)) u_wrap (
    .clk(clk), .rst(rst), .uart_empty(uart_empty), .uart_in(uart_in),
    .uart_rdreq(w_rdreq), .imem_we(w_we), .imem_addr(w_addr),
    .imem_wdata(w_wdata), .core_run(w_core_run), .status(w_status),
    .words_loaded(w_words_loaded));

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  byte_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] wbuf[0:7];
  logic [31:0] exp_n, ed;
  logic [31:0] w_addr_q[$];
  bit          exp_err, stall_en, prev_rd;
  int          cyc, wr_cnt, done_cyc, err_cyc;
  int          we_cyc[$], rd_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expected write list and protocol rules.
  always @(negedge clk) begin
    if (rst) prev_rd = 1'b0;
    else begin
      if (uart_rdreq) begin
        chk("rdreq_while_empty", {31'd0, uart_empty}, 32'd0);
        chk("rdreq_back_to_back", {31'd0, prev_rd}, 32'd0);
        rd_cyc.push_back(cyc);
      end
      chk("wrap_rdreq_match", {31'd0, w_rdreq}, {31'd0, uart_rdreq});
      chk("wrap_we_match", {31'd0, w_we}, {31'd0, imem_we});
      chk("wrap_status_match", {30'd0, w_status}, {30'd0, status});
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", imem_addr, imem_wdata);
        end else begin
          ed = exp_q.pop_front();
          chk("wdata", imem_wdata, ed);
          chk("wrap_wdata", w_wdata, ed);
          chk("addr", imem_addr, 32'(wr_cnt) << 2);
          chk("wrap_addr", w_addr, 32'hFFFF_FFFC + (32'(wr_cnt) << 2));
          chk("words_loaded_at_write", words_loaded, 32'(wr_cnt));
          w_addr_q.push_back(w_addr);
          wr_cnt++;
          we_cyc.push_back(cyc);
        end
      end
      chk("core_run_vs_status", {31'd0, core_run}, {31'd0, status == 2'd2});
      chk("wrap_core_run", {31'd0, w_core_run}, {31'd0, core_run});
      if (status == 2'd2) begin
        if (done_cyc < 0) done_cyc = cyc;
        chk("done_pending_writes", 32'(exp_q.size()), 32'd0);
        chk("done_words_loaded", words_loaded, exp_n);
        chk("wrap_words_loaded", w_words_loaded, exp_n);
      end
      if (status == 2'd3) begin
        if (err_cyc < 0) err_cyc = cyc;
        chk("error_expected", {31'd0, exp_err}, 32'd1);
      end
      prev_rd = uart_rdreq;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) byte_q.push_back(8'(w >> (8 * i)));
  endtask

  task automatic load_img(input logic [31:0] n, input int nw, input bit err);
    push_word(n);
    for (int i = 0; i < nw; i++) begin
      push_word(wbuf[i]);
      if (!err) exp_q.push_back(wbuf[i]);
    end
    exp_n   = err ? 32'hFFFF_FFFF : n;
    exp_err = err;
  endtask

  task automatic begin_reset(input bit stall);
    rst = 1'b1;
    uart_empty = 1'b1;
    repeat (2) @(posedge clk);
    byte_q.delete(); exp_q.delete(); w_addr_q.delete();
    we_cyc.delete(); rd_cyc.delete();
    wr_cnt = 0; done_cyc = -1; err_cyc = -1; stall_en = stall;
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    uart_empty = (byte_q.size() == 0) || (stall_en && ($urandom_range(1, 0) == 1));
  endtask

  // One cycle of FIFO behaviour: a request seen this cycle returns its byte next cycle.
  task automatic step();
    logic r;
    @(negedge clk);
    r = uart_rdreq;
    @(posedge clk); #1;
    cyc++;
    if (r && byte_q.size() > 0) uart_in = byte_q.pop_front();
    uart_empty = (byte_q.size() == 0) || (stall_en && ($urandom_range(1, 0) == 1));
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  initial begin
    #1;
    // Reset values
    begin_reset(1'b0);
    #1;
    chk("rst_rdreq", {31'd0, uart_rdreq}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_core_run", {31'd0, core_run}, 32'd0);
    chk("rst_status", {30'd0, status}, 32'd0);
    chk("rst_words_loaded", words_loaded, 32'd0);

    // N=2, FIFO never empty, trailing bytes must stay in the FIFO
    wbuf[0] = 32'h0000_0013; wbuf[1] = 32'hDEAD_BEEF;
    load_img(32'd2, 2, 1'b0);
    repeat (3) byte_q.push_back(8'hAA);
    release_rst();
    run(40);
    chk("n2_we_count", 32'(we_cyc.size()), 32'd2);
    chk("n2_we0_cycle", 32'(we_cyc[0]), 32'd16);
    chk("n2_we1_cycle", 32'(we_cyc[1]), 32'd25);
    chk("n2_done_cycle", 32'(done_cyc), 32'd26);
    chk("n2_rd_count", 32'(rd_cyc.size()), 32'd12);
    chk("n2_rd0", 32'(rd_cyc[0]), 32'd0);
    chk("n2_rd1", 32'(rd_cyc[1]), 32'd2);
    chk("n2_rd3", 32'(rd_cyc[3]), 32'd6);
    chk("n2_rd4", 32'(rd_cyc[4]), 32'd8);
    chk("n2_leftover", 32'(byte_q.size()), 32'd3);
    chk("n2_words_loaded", words_loaded, 32'd2);
    chk("n2_status", {30'd0, status}, 32'd2);
    chk("n2_addr_hold", imem_addr, 32'h4);
    chk("n2_wdata_hold", imem_wdata, 32'hDEAD_BEEF);
    chk("wrap_addr0", w_addr_q[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", w_addr_q[1], 32'h0000_0000);

    // N=0: done at cycle 8, FIFO contents untouched afterwards
    begin_reset(1'b0);
    load_img(32'd0, 0, 1'b0);
    repeat (4) byte_q.push_back(8'h55);
    release_rst();
    run(20);
    chk("n0_done_cycle", 32'(done_cyc), 32'd8);
    chk("n0_we_count", 32'(we_cyc.size()), 32'd0);
    chk("n0_rd_count", 32'(rd_cyc.size()), 32'd4);
    chk("n0_leftover", 32'(byte_q.size()), 32'd4);
    chk("n0_core_run", {31'd0, core_run}, 32'd1);

    // N=MAX_WORDS+1: error at cycle 8, nothing more happens
    begin_reset(1'b0);
    load_img(32'd5, 0, 1'b1);
    repeat (8) byte_q.push_back(8'h77);
    release_rst();
    run(30);
    chk("err_cycle", 32'(err_cyc), 32'd8);
    chk("err_status", {30'd0, status}, 32'd3);
    chk("err_rd_count", 32'(rd_cyc.size()), 32'd4);
    chk("err_we_count", 32'(we_cyc.size()), 32'd0);
    chk("err_leftover", 32'(byte_q.size()), 32'd8);
    chk("err_core_run", {31'd0, core_run}, 32'd0);

    // N=1 with random FIFO stalls, byte order 78 56 34 12
    begin_reset(1'b1);
    push_word(32'd1);
    byte_q.push_back(8'h78); byte_q.push_back(8'h56);
    byte_q.push_back(8'h34); byte_q.push_back(8'h12);
    exp_q.push_back(32'h1234_5678);
    exp_n = 32'd1; exp_err = 1'b0;
    release_rst();
    for (int i = 0; i < 300 && status != 2'd2; i++) step();
    chk("stall_status", {30'd0, status}, 32'd2);
    chk("stall_we_count", 32'(we_cyc.size()), 32'd1);
    chk("stall_wdata", imem_wdata, 32'h1234_5678);
    chk("stall_words_loaded", words_loaded, 32'd1);

    // N=MAX_WORDS is accepted
    begin_reset(1'b0);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
    load_img(32'd4, 4, 1'b0);
    release_rst();
    run(60);
    chk("max_we_count", 32'(we_cyc.size()), 32'd4);
    chk("max_we3_cycle", 32'(we_cyc[3]), 32'd43);
    chk("max_done_cycle", 32'(done_cyc), 32'd44);

    // Reset during the 3rd byte of word 1, then a fresh N=1 image
    begin_reset(1'b0);
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222; wbuf[2] = 32'h3333_3333;
    load_img(32'd3, 3, 1'b0);
    release_rst();
    run(21);
    chk("mid_rdreq_w1b3", {31'd0, uart_rdreq}, 32'd1);
    chk("mid_words_before", words_loaded, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdreq", {31'd0, uart_rdreq}, 32'd0);
    chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_wdata", imem_wdata, 32'h0);
    chk("mid_rst_status", {30'd0, status}, 32'd0);
    chk("mid_rst_words", words_loaded, 32'd0);
    begin_reset(1'b0);
    wbuf[0] = 32'hCAFE_F00D;
    load_img(32'd1, 1, 1'b0);
    release_rst();
    run(30);
    chk("fresh_we_count", 32'(we_cyc.size()), 32'd1);
    chk("fresh_we_cycle", 32'(we_cyc[0]), 32'd16);
    chk("fresh_done_cycle", 32'(done_cyc), 32'd17);
    chk("fresh_addr", imem_addr, 32'h0);
    chk("fresh_wdata", imem_wdata, 32'hCAFE_F00D);
    chk("fresh_words_loaded", words_loaded, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
